// File: rtl/data_ram_pkg.sv
// Shared definitions for the riscv32i data memory.
//   SIZE_B / SIZE_H / SIZE_W : a_size encodings for byte, half and word accesses
//   lane_mask()              : byte-enable pattern for a store of a given size/offset
//   load_ext()               : lane select plus sign/zero extension of a loaded word
package data_ram_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Byte lanes touched by a store; an illegal size gives no lanes at all.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SIZE_B:  mask = 4'b0001 << off;
            SIZE_H:  mask = 4'b0011 << {off[1], 1'b0};
            SIZE_W:  mask = 4'hF;
            default: mask = 4'h0;
        endcase
        return mask;
    endfunction

    // Shift the addressed lane down to bit 0, then extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic is_unsigned);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SIZE_B:  res = is_unsigned ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SIZE_H:  res = is_unsigned ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            SIZE_W:  res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_ram_sp.sv
// Single-port synchronous RAM, 32-bit words with byte write enables.
//   clk  : clock
//   be   : per-byte write enable (bit i writes din[8i+7:8i])
//   addr : word address
//   din  : write data
//   dout : registered read data, read-first (returns the word as it was before a write)
// Contents are deliberately not reset.
module data_ram_sp #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem_r [DEPTH];

    // Byte-lane writes and read-first registered read on the same address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem_r[addr][i*8 +: 8] <= din[i*8 +: 8];
            end
        end
        dout <= mem_r[addr];
    end

endmodule

// File: rtl/data_ram_arb.sv
// Two-port data memory for the riscv32i core over one single-ported RAM.
//   clk, rst_n            : clock, asynchronous active-low reset
//   a_req/a_ready         : CPU load/store handshake (transfer = a_req & a_ready)
//   a_we, a_size, a_unsigned, a_addr, a_wdata : CPU access attributes
//   a_rvalid/a_rdata/a_err: CPU response, one pulse per accepted request
//   b_req/b_ready         : debug handshake, word-wide
//   b_we, b_addr, b_wdata : debug access attributes (b_addr is a word index)
//   b_rvalid/b_rdata      : debug response, one pulse per accepted request
// Port A has priority; port B is forced through after STARVE_MAX stalled cycles.
// Responses arrive 1+RD_PIPE cycles after acceptance.
module data_ram_arb
    import data_ram_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RD_PIPE     = 0,
    parameter int          STARVE_MAX  = 8,
    localparam int         LW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [1:0]    a_size,
    input  logic          a_unsigned,
    input  logic [31:0]   a_addr,
    input  logic [31:0]   a_wdata,
    output logic          a_rvalid,
    output logic [31:0]   a_rdata,
    output logic          a_err,
    input  logic          b_req,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [LW-1:0] b_addr,
    input  logic [31:0]   b_wdata,
    output logic          b_rvalid,
    output logic [31:0]   b_rdata
);

    localparam int          SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [31:0] SPAN       = 32'(DEPTH_WORDS * 4);

    // Arbitration
    logic [SW-1:0] starve_cnt_r;
    logic [SW-1:0] starve_nxt_s;
    logic          b_force_s;
    logic          a_grant_s;
    logic          b_grant_s;

    assign b_force_s = b_req & (starve_cnt_r == STARVE_LIM);
    assign a_ready   = ~b_force_s;
    assign b_ready   = b_force_s | ~a_req;
    assign a_grant_s = a_req & a_ready;
    assign b_grant_s = b_req & b_ready;

    // Starvation counter: counts stalled B cycles, saturating at the limit.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (!b_req || b_grant_s) begin
            starve_nxt_s = '0;
        end else if (starve_cnt_r != STARVE_LIM) begin
            starve_nxt_s = starve_cnt_r + 1'b1;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= '0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
        end
    end

    // Port A address check; the subtraction wraps so addresses below the base fail too.
    logic [31:0]   a_off_s;
    logic          a_in_range_s;
    logic          a_misal_s;
    logic          a_bad_s;
    logic [LW-1:0] a_word_s;

    assign a_off_s      = a_addr - BASE_ADDR;
    assign a_in_range_s = (a_off_s < SPAN);
    assign a_word_s     = a_off_s[LW+1:2];
    assign a_bad_s      = ~a_in_range_s | a_misal_s;

    // Alignment rules per access size; size 3 is always rejected.
    always_comb begin
        a_misal_s = 1'b1;
        case (a_size)
            SIZE_B:  a_misal_s = 1'b0;
            SIZE_H:  a_misal_s = a_addr[0];
            SIZE_W:  a_misal_s = (a_addr[1:0] != 2'b00);
            default: a_misal_s = 1'b1;
        endcase
    end

    // Store data replicated so every candidate lane carries the right bytes.
    logic [31:0] a_wrep_s;

    // Store data replication by size.
    always_comb begin
        a_wrep_s = a_wdata;
        case (a_size)
            SIZE_B:  a_wrep_s = {4{a_wdata[7:0]}};
            SIZE_H:  a_wrep_s = {2{a_wdata[15:0]}};
            default: a_wrep_s = a_wdata;
        endcase
    end

    // RAM port multiplexing
    logic [3:0]    ram_be_s;
    logic [LW-1:0] ram_addr_s;
    logic [31:0]   ram_din_s;
    logic [31:0]   ram_dout_s;

    // Steer the granted port onto the RAM; errored A stores write nothing.
    always_comb begin
        ram_be_s   = 4'h0;
        ram_addr_s = a_word_s;
        ram_din_s  = a_wrep_s;
        if (b_grant_s) begin
            ram_addr_s = b_addr;
            ram_din_s  = b_wdata;
            ram_be_s   = b_we ? 4'hF : 4'h0;
        end else if (a_grant_s && a_we && !a_bad_s) begin
            ram_be_s = lane_mask(a_size, a_addr[1:0]);
        end else begin
            ram_be_s = 4'h0;
        end
    end

    data_ram_sp #(
        .DEPTH (DEPTH_WORDS),
        .AW    (LW)
    ) u_ram (
        .clk  (clk),
        .be   (ram_be_s),
        .addr (ram_addr_s),
        .din  (ram_din_s),
        .dout (ram_dout_s)
    );

    // Stage 1: request attributes travel alongside the RAM read.
    logic       s1_a_vld_r;
    logic       s1_b_vld_r;
    logic       s1_we_r;
    logic       s1_err_r;
    logic [1:0] s1_size_r;
    logic       s1_uns_r;
    logic [1:0] s1_off_r;

    // Stage-1 sideband registers aligned with the RAM output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_vld_r <= 1'b0;
            s1_b_vld_r <= 1'b0;
            s1_we_r    <= 1'b0;
            s1_err_r   <= 1'b0;
            s1_size_r  <= 2'd0;
            s1_uns_r   <= 1'b0;
            s1_off_r   <= 2'd0;
        end else begin
            s1_a_vld_r <= a_grant_s;
            s1_b_vld_r <= b_grant_s;
            s1_we_r    <= b_grant_s ? b_we : a_we;
            s1_err_r   <= a_grant_s & a_bad_s;
            s1_size_r  <= a_size;
            s1_uns_r   <= a_unsigned;
            s1_off_r   <= a_addr[1:0];
        end
    end

    // Responses formed at the output of stage 1; idle, store and error slots read as 0.
    logic        s1_a_rvalid_s;
    logic [31:0] s1_a_rdata_s;
    logic        s1_a_err_s;
    logic        s1_b_rvalid_s;
    logic [31:0] s1_b_rdata_s;

    assign s1_a_rvalid_s = s1_a_vld_r;
    assign s1_a_err_s    = s1_a_vld_r & s1_err_r;
    assign s1_a_rdata_s  = (s1_a_vld_r & ~s1_we_r & ~s1_err_r)
                         ? load_ext(ram_dout_s, s1_size_r, s1_off_r, s1_uns_r) : 32'h0000_0000;
    assign s1_b_rvalid_s = s1_b_vld_r;
    assign s1_b_rdata_s  = (s1_b_vld_r & ~s1_we_r) ? ram_dout_s : 32'h0000_0000;

    generate
        if (RD_PIPE == 0) begin : g_direct
            assign a_rvalid = s1_a_rvalid_s;
            assign a_rdata  = s1_a_rdata_s;
            assign a_err    = s1_a_err_s;
            assign b_rvalid = s1_b_rvalid_s;
            assign b_rdata  = s1_b_rdata_s;
        end else begin : g_piped
            // Extra output register stage for timing closure.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rvalid <= 1'b0;
                    a_rdata  <= 32'h0000_0000;
                    a_err    <= 1'b0;
                    b_rvalid <= 1'b0;
                    b_rdata  <= 32'h0000_0000;
                end else begin
                    a_rvalid <= s1_a_rvalid_s;
                    a_rdata  <= s1_a_rdata_s;
                    a_err    <= s1_a_err_s;
                    b_rvalid <= s1_b_rvalid_s;
                    b_rdata  <= s1_b_rdata_s;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_data_ram_arb.sv
// Self-checking bench for data_ram_arb (RD_PIPE=1, STARVE_MAX=8) with a byte-level
// reference memory kept in the bench.
module tb_data_ram_arb;

    localparam int DEPTH = 4096;
    localparam int LWB   = 12;
    localparam int RDP   = 1;
    localparam int LAT   = 1 + RDP;
    localparam int SMAX  = 8;

    logic           clk;
    logic           rst_n;
    logic           a_req, a_ready, a_we, a_unsigned, a_rvalid, a_err;
    logic [1:0]     a_size;
    logic [31:0]    a_addr, a_wdata, a_rdata;
    logic           b_req, b_ready, b_we, b_rvalid;
    logic [LWB-1:0] b_addr;
    logic [31:0]    b_wdata, b_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [64];

    data_ram_arb #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000),
        .RD_PIPE     (RDP),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .a_req (a_req), .a_ready (a_ready), .a_we (a_we), .a_size (a_size),
        .a_unsigned (a_unsigned), .a_addr (a_addr), .a_wdata (a_wdata),
        .a_rvalid (a_rvalid), .a_rdata (a_rdata), .a_err (a_err),
        .b_req (b_req), .b_ready (b_ready), .b_we (b_we), .b_addr (b_addr),
        .b_wdata (b_wdata), .b_rvalid (b_rvalid), .b_rdata (b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic m_err(input logic [31:0] addr, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        if (addr >= 32'(DEPTH * 4)) return 1'b1;
        if (sz == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] sz,
                                           input logic uns);
        logic [31:0] w;
        logic [31:0] v;
        int off;
        w   = mem_m[addr[7:2]];
        off = int'(addr % 4);
        v   = w;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'h0000_00FF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (8 * off)) & 32'h0000_FFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        int nb;
        int off;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(addr % 4);
        for (int k = 0; k < nb; k++) begin
            mem_m[addr[7:2]][8*(off+k) +: 8] = wd[8*k +: 8];
        end
    endtask

    // ---------------- drivers ----------------
    task automatic a_xfer(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic rv, output logic [31:0] rd, output logic er,
                          output logic stray);
        logic got;
        got = 1'b0; stray = 1'b0; rv = 1'b0; rd = 32'h0; er = 1'b0;
        @(negedge clk);
        a_req = 1'b1; a_we = we; a_size = sz; a_unsigned = uns; a_addr = addr; a_wdata = wd;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (a_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL a_accept_timeout: a_ready=%0b required=1", a_ready);
            a_req = 1'b0;
        end else begin
            @(posedge clk); #1 a_req = 1'b0;
            for (int c = 1; c <= LAT + 1; c++) begin
                @(negedge clk);
                if (c == LAT) begin
                    rv = a_rvalid; rd = a_rdata; er = a_err;
                end else if (a_rvalid) begin
                    stray = 1'b1;
                end
            end
        end
    endtask

    task automatic b_xfer(input logic we, input logic [LWB-1:0] addr, input logic [31:0] wd,
                          output logic rv, output logic [31:0] rd, output logic stray);
        logic got;
        got = 1'b0; stray = 1'b0; rv = 1'b0; rd = 32'h0;
        @(negedge clk);
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (b_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL b_accept_timeout: b_ready=%0b required=1", b_ready);
            b_req = 1'b0;
        end else begin
            @(posedge clk); #1 b_req = 1'b0;
            for (int c = 1; c <= LAT + 1; c++) begin
                @(negedge clk);
                if (c == LAT) begin
                    rv = b_rvalid; rd = b_rdata;
                end else if (b_rvalid) begin
                    stray = 1'b1;
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({a_rvalid, a_err, b_rvalid, a_rdata, b_rdata} !== 67'h0) begin
            failures++;
            $display("FAIL reset_outputs: got rv=%0b err=%0b brv=%0b ard=%h brd=%h required all 0",
                     a_rvalid, a_err, b_rvalid, a_rdata, b_rdata);
        end
        checks++;
        if ({a_ready, b_ready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_ready: got %b required 11", {a_ready, b_ready});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic init_mem();
        logic rv, st;
        logic [31:0] rd;
        for (int w = 0; w < 64; w++) begin
            mem_m[w] = $urandom;
            b_xfer(1'b1, LWB'(w), mem_m[w], rv, rd, st);
            if (w < 2) begin
                checks++;
                if (rv !== 1'b1 || rd !== 32'h0 || st !== 1'b0) begin
                    failures++;
                    $display("FAIL b_write_resp: rv=%0b rd=%h stray=%0b required 1/0/0", rv, rd, st);
                end
            end
        end
    endtask

    task automatic test_loadstore();
        logic rv, er, st;
        logic [31:0] rd;
        logic [31:0] exp_v [4];
        logic [1:0]  szs   [4];
        logic        unss  [4];
        logic [31:0] adrs  [4];
        exp_v = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'hDEAD_BEEF};
        szs   = '{2'd0, 2'd0, 2'd1, 2'd2};
        unss  = '{1'b0, 1'b1, 1'b0, 1'b0};
        adrs  = '{32'h13, 32'h13, 32'h12, 32'h10};
        a_xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rv, rd, er, st);
        m_store(32'h10, 2'd2, 32'hDEAD_BEEF);
        checks++;
        if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0 || st !== 1'b0) begin
            failures++;
            $display("FAIL sw_resp: rv=%0b err=%0b rd=%h stray=%0b required 1/0/0/0", rv, er, rd, st);
        end
        for (int i = 0; i < 4; i++) begin
            a_xfer(1'b0, szs[i], unss[i], adrs[i], 32'h0, rv, rd, er, st);
            checks++;
            if (rv !== 1'b1 || er !== 1'b0 || rd !== exp_v[i] || st !== 1'b0) begin
                failures++;
                $display("FAIL load_%0d: rv=%0b err=%0b rd=%h stray=%0b required 1/0/%h/0",
                         i, rv, er, rd, st, exp_v[i]);
            end
        end
    endtask

    task automatic test_sb();
        logic rv, er, st;
        logic [31:0] rd;
        b_xfer(1'b1, LWB'(8), 32'h0, rv, rd, st);
        mem_m[8] = 32'h0;
        a_xfer(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0012, rv, rd, er, st);
        m_store(32'h21, 2'd0, 32'h0000_0012);
        a_xfer(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rv, rd, er, st);
        checks++;
        if (rv !== 1'b1 || rd !== 32'h0000_1200 || er !== 1'b0) begin
            failures++;
            $display("FAIL sb_lane1: rv=%0b rd=%h err=%0b required 1/00001200/0", rv, rd, er);
        end
    endtask

    task automatic test_errors();
        logic rv, er, st;
        logic [31:0] rd;
        logic        wes  [3];
        logic [1:0]  szs  [3];
        logic [31:0] adrs [3];
        wes  = '{1'b0, 1'b1, 1'b1};
        szs  = '{2'd2, 2'd1, 2'd2};
        adrs = '{32'h02, 32'h01, 32'(DEPTH * 4)};
        for (int i = 0; i < 3; i++) begin
            a_xfer(wes[i], szs[i], 1'b0, adrs[i], $urandom, rv, rd, er, st);
            checks++;
            if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0 || st !== 1'b0) begin
                failures++;
                $display("FAIL err_%0d: rv=%0b err=%0b rd=%h stray=%0b required 1/1/0/0",
                         i, rv, er, rd, st);
            end
        end
        for (int w = 0; w < 2; w++) begin
            b_xfer(1'b0, LWB'(w), 32'h0, rv, rd, st);
            checks++;
            if (rv !== 1'b1 || rd !== mem_m[w]) begin
                failures++;
                $display("FAIL err_nowrite_w%0d: rv=%0b rd=%h required 1/%h", w, rv, rd, mem_m[w]);
            end
        end
    endtask

    task automatic test_b_then_a();
        logic got;
        got = 1'b0;
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = LWB'(5); b_wdata = 32'hCAFE_F00D;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (b_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL b_then_a_timeout: b_ready=%0b required=1", b_ready);
            b_req = 1'b0;
        end else begin
            mem_m[5] = 32'hCAFE_F00D;
            @(posedge clk); #1;
            b_req = 1'b0;
            a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_unsigned = 1'b0; a_addr = 32'h14;
            @(posedge clk); #1 a_req = 1'b0;
            repeat (LAT - 1) @(posedge clk);
            @(negedge clk);
            if (a_rvalid !== 1'b1 || a_rdata !== 32'hCAFE_F00D) begin
                failures++;
                $display("FAIL b_then_a: rv=%0b rd=%h required 1/cafef00d", a_rvalid, a_rdata);
            end
        end
    endtask

    task automatic test_random();
        logic rv, er, st;
        logic [31:0] rd, addr, wd, exp_rd;
        logic [1:0]  sz;
        logic        we, uns, exp_er;
        int          w;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                w = $urandom_range(0, 63);
                b_xfer(1'b0, LWB'(w), 32'h0, rv, rd, st);
                checks++;
                if (rv !== 1'b1 || rd !== mem_m[w] || st !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_b_%0d: rv=%0b rd=%h stray=%0b required 1/%h/0",
                             n, rv, rd, st, mem_m[w]);
                end
            end else begin
                sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                addr = ($urandom_range(0, 9) == 0) ? 32'(DEPTH * 4) + $urandom_range(0, 255)
                                                   : 32'($urandom_range(0, 255));
                we   = 1'($urandom_range(0, 1));
                uns  = 1'($urandom_range(0, 1));
                wd   = $urandom;
                exp_er = m_err(addr, sz);
                exp_rd = (we || exp_er) ? 32'h0 : m_load(addr, sz, uns);
                if (we && !exp_er) m_store(addr, sz, wd);
                a_xfer(we, sz, uns, addr, wd, rv, rd, er, st);
                checks++;
                if (rv !== 1'b1 || er !== exp_er || rd !== exp_rd || st !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_a_%0d: we=%0b sz=%0d addr=%h rv=%0b err=%0b rd=%h stray=%0b required 1/%0b/%h/0",
                             n, we, sz, addr, rv, er, rd, st, exp_er, exp_rd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd [8];
        logic        exp_er [8];
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        uns;
        for (int i = 0; i < 8 + LAT; i++) begin
            @(negedge clk);
            if (i >= LAT) begin
                checks++;
                if (a_rvalid !== 1'b1 || a_err !== exp_er[i-LAT] || a_rdata !== exp_rd[i-LAT]) begin
                    failures++;
                    $display("FAIL b2b_%0d: rv=%0b err=%0b rd=%h required 1/%0b/%h",
                             i - LAT, a_rvalid, a_err, a_rdata, exp_er[i-LAT], exp_rd[i-LAT]);
                end
            end
            if (i < 8) begin
                sz   = 2'($urandom_range(0, 2));
                addr = 32'($urandom_range(0, 255));
                uns  = 1'($urandom_range(0, 1));
                exp_er[i] = m_err(addr, sz);
                exp_rd[i] = exp_er[i] ? 32'h0 : m_load(addr, sz, uns);
                a_req = 1'b1; a_we = 1'b0; a_size = sz; a_unsigned = uns; a_addr = addr;
            end else begin
                a_req = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_tail: rv=%0b required 0", a_rvalid);
        end
    endtask

    task automatic test_starve();
        int pulses;
        logic exp_b;
        pulses = 0;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_unsigned = 1'b0; a_addr = 32'h0;
        b_req = 1'b1; b_we = 1'b0; b_addr = LWB'(1);
        for (int i = 1; i <= 27; i++) begin
            #1;
            exp_b = ((i % (SMAX + 1)) == 0);
            if (b_ready) pulses++;
            checks++;
            if (b_ready !== exp_b || a_ready !== !exp_b) begin
                failures++;
                $display("FAIL starve_cyc%0d: b_ready=%0b a_ready=%0b required %0b/%0b",
                         i, b_ready, a_ready, exp_b, !exp_b);
            end
            @(negedge clk);
        end
        a_req = 1'b0; b_req = 1'b0;
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL starve_pulses: got %0d required 3", pulses);
        end
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        logic stray_s, rv, er, st;
        logic [31:0] rd;
        stray_s = 1'b0;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_unsigned = 1'b0; a_addr = 32'h10;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0; a_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL inflight_in_reset: a_rvalid=%0b b_rvalid=%0b required 0/0", a_rvalid, b_rvalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_rvalid || b_rvalid) stray_s = 1'b1;
        end
        checks++;
        if (stray_s !== 1'b0) begin
            failures++;
            $display("FAIL inflight_dropped: stray rvalid=%0b required 0", stray_s);
        end
        a_xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rv, rd, er, st);
        checks++;
        if (rv !== 1'b1 || er !== 1'b0 || rd !== mem_m[4] || st !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_lw: rv=%0b err=%0b rd=%h stray=%0b required 1/0/%h/0",
                     rv, er, rd, st, mem_m[4]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_size = 2'd0; a_unsigned = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = 32'h0;
        test_reset();
        init_mem();
        test_loadstore();
        test_sb();
        test_errors();
        test_b_then_a();
        test_random();
        test_back_to_back();
        test_starve();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
